// File: rtl/ps2_letter_rx_if.sv
// ps2_letter_rx_if: key event outputs of the PS/2 letter receiver.
// pressed     - single-cycle pulse on a new letter key press
// inputLetter - letter index 0 (A) .. 25 (Z), held until the next press
// frame_err   - single-cycle pulse when a received frame is discarded
interface ps2_letter_rx_if;
    logic       pressed;
    logic [4:0] inputLetter;
    logic       frame_err;
    modport master (output pressed, inputLetter, frame_err);
    modport slave  (input  pressed, inputLetter, frame_err);
endinterface

// File: rtl/ps2_letter_rx.sv
// ps2_letter_rx: PS/2 set-2 keyboard receiver that reports letter key presses.
// Ports: clk (system clock), reset (async, active high), PS2_CLK/PS2_DAT (raw
// device lines, asynchronous to clk), out_if (master: pressed, inputLetter, frame_err).
// Optional macro PS2_PARITY_CHECK_EN: reject frames whose odd parity is wrong.
module ps2_letter_rx #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PS2_CLK,
    input  logic                   PS2_DAT,
    ps2_letter_rx_if.master        out_if
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
    logic                   r_clk_prev;
    logic [2:0]             r_cnt;
    logic [7:0]             r_shift;
    logic [TW-1:0]          r_timer;
    logic                   r_byte_valid;
    logic                   r_ext, r_brk, r_held;
    logic [7:0]             r_held_code;
    logic                   r_pressed, r_frame_err;
    logic [4:0]             r_letter;
    logic                   w_clk, w_dat, w_edge, w_par_bad;
    logic [5:0]             w_letter;

    // {is_letter, index} for a set-2 make code
    function automatic logic [5:0] f_letter(input logic [7:0] c);
        case (c)
            8'h1C: return {1'b1, 5'd0};
            8'h32: return {1'b1, 5'd1};
            8'h21: return {1'b1, 5'd2};
            8'h23: return {1'b1, 5'd3};
            8'h24: return {1'b1, 5'd4};
            8'h2B: return {1'b1, 5'd5};
            8'h34: return {1'b1, 5'd6};
            8'h33: return {1'b1, 5'd7};
            8'h43: return {1'b1, 5'd8};
            8'h3B: return {1'b1, 5'd9};
            8'h42: return {1'b1, 5'd10};
            8'h4B: return {1'b1, 5'd11};
            8'h3A: return {1'b1, 5'd12};
            8'h31: return {1'b1, 5'd13};
            8'h44: return {1'b1, 5'd14};
            8'h4D: return {1'b1, 5'd15};
            8'h15: return {1'b1, 5'd16};
            8'h2D: return {1'b1, 5'd17};
            8'h1B: return {1'b1, 5'd18};
            8'h2C: return {1'b1, 5'd19};
            8'h3C: return {1'b1, 5'd20};
            8'h2A: return {1'b1, 5'd21};
            8'h1D: return {1'b1, 5'd22};
            8'h22: return {1'b1, 5'd23};
            8'h35: return {1'b1, 5'd24};
            8'h1A: return {1'b1, 5'd25};
            default: return 6'd0;
        endcase
    endfunction

    assign w_clk    = r_clk_sync[SYNC_STAGES-1];
    assign w_dat    = r_dat_sync[SYNC_STAGES-1];
    assign w_edge   = r_clk_prev & ~w_clk;
    assign w_letter = f_letter(r_shift);

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;
    // valid frames carry an odd number of ones across data and parity
    assign w_par_bad = ~^{r_shift, r_parity};
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_clk_sync   <= '1;
            r_dat_sync   <= '1;
            r_clk_prev   <= 1'b1;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_timer      <= '0;
            r_byte_valid <= 1'b0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_held       <= 1'b0;
            r_held_code  <= '0;
            r_pressed    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_letter     <= '0;
`ifdef PS2_PARITY_CHECK_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            r_dat_sync   <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DAT};
            r_clk_prev   <= w_clk;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_pressed    <= 1'b0;
            if (r_state != IDLE && !w_edge && r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_timer     <= '0;
                r_frame_err <= 1'b1;
            end else if (w_edge) begin
                r_timer <= '0;
                case (r_state)
                    IDLE: if (!w_dat) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                    end
                    DATA: begin
                        r_shift <= {w_dat, r_shift[7:1]};
                        r_cnt   <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) r_state <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_parity <= w_dat;
`endif
                        r_state <= STOP;
                    end
                    default: begin
                        if (!w_dat || w_par_bad) r_frame_err <= 1'b1;
                        else r_byte_valid <= 1'b1;
                        r_state <= IDLE;
                    end
                endcase
            end else if (r_state != IDLE) begin
                r_timer <= r_timer + 1'b1;
            end
            // byte processing runs the cycle after the stop-bit edge
            if (r_byte_valid) begin
                if (r_shift == 8'hE0) r_ext <= 1'b1;
                else if (r_shift == 8'hF0) r_brk <= 1'b1;
                else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (r_brk) begin
                        if (r_held && r_shift == r_held_code) r_held <= 1'b0;
                    end else if (!r_ext && w_letter[5] && !(r_held && r_shift == r_held_code)) begin
                        r_pressed   <= 1'b1;
                        r_letter    <= w_letter[4:0];
                        r_held      <= 1'b1;
                        r_held_code <= r_shift;
                    end
                end
            end
        end
    end

    assign out_if.pressed     = r_pressed;
    assign out_if.inputLetter = r_letter;
    assign out_if.frame_err   = r_frame_err;
endmodule

// File: tb/tb_ps2_letter_rx.sv
// tb_ps2_letter_rx: scoreboard bench driving PS/2 frames into ps2_letter_rx.
module tb_ps2_letter_rx;
    localparam int HALF = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic PS2_CLK = 1'b1;
    logic PS2_DAT = 1'b1;

    ps2_letter_rx_if bus ();

    ps2_letter_rx dut (
        .clk     (clk),
        .reset   (reset),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .out_if  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [4:0] letter;
        int         lat;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_fall = 0;
    logic prev_p = 1'b0;
    logic prev_e = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (bus.pressed || bus.frame_err)) begin
            check("no_back_to_back", int'((bus.pressed && prev_p) || (bus.frame_err && prev_e)), 0);
            check("single_pulse_kind", int'(bus.pressed && bus.frame_err), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind_err", int'(bus.frame_err), int'(mon_e.err));
                if (!mon_e.err) check("letter", int'(bus.inputLetter), int'(mon_e.letter));
                if (mon_e.lat != 0) check("latency", cyc - last_fall, mon_e.lat);
            end
        end
        prev_p = bus.pressed;
        prev_e = bus.frame_err;
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        PS2_DAT = b;
        repeat (HALF) @(negedge clk);
        PS2_CLK = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input logic par_ok, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_ok ? ~^b : ^b);
        ps2_bit(stop);
        repeat (20) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] b, input logic [4:0] letter);
        exp_q.push_back('{err: 1'b0, letter: letter, lat: 4});
        frame(b, 1'b1, 1'b1);
    endtask

    task automatic quiet(input logic [7:0] b);
        frame(b, 1'b1, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_pressed", int'(bus.pressed), 0);
        check("reset_letter", int'(bus.inputLetter), 0);
        check("reset_frame_err", int'(bus.frame_err), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        press(8'h1C, 5'd0);
        quiet(8'hF0); quiet(8'h1C);

        press(8'h1C, 5'd0);
        quiet(8'h1C); quiet(8'h1C);
        quiet(8'hF0); quiet(8'h1C);
        press(8'h1C, 5'd0);

        press(8'h1A, 5'd25);
        press(8'h35, 5'd24);
        quiet(8'hE0); quiet(8'h1C);
        press(8'h1C, 5'd0);

        exp_q.push_back('{err: 1'b1, letter: 5'd0, lat: 3});
        frame(8'h24, 1'b1, 1'b0);
        press(8'h24, 5'd4);

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        exp_q.push_back('{err: 1'b1, letter: 5'd0, lat: 0});
        repeat (50020) @(negedge clk);
        check("timeout_drained", exp_q.size(), 0);
        press(8'h15, 5'd16);

`ifdef PS2_PARITY_CHECK_EN
        exp_q.push_back('{err: 1'b1, letter: 5'd0, lat: 3});
`else
        exp_q.push_back('{err: 1'b0, letter: 5'd0, lat: 4});
`endif
        frame(8'h1C, 1'b0, 1'b1);

        quiet(8'hE0); quiet(8'hF0); quiet(8'h1C);
        press(8'h1C, 5'd0);

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_pressed", int'(bus.pressed), 0);
        check("midreset_letter", int'(bus.inputLetter), 0);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        press(8'h32, 5'd1);

        quiet(8'h16);
        press(8'h2B, 5'd5);

        repeat (50) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_letter_rx.md
PS2_LETTER_RX -- requirements
Module: ps2_letter_rx

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 50000, idle clk cycles mid-frame before the frame is abandoned (1 ms at 50 MHz).
REQ-002 Parameter: SYNC_STAGES, 2, flip-flop stages on PS2_CLK and PS2_DAT; minimum 2.
REQ-003 Port: clk  input  1  system clock, 50 MHz; the only clock.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: PS2_CLK  input  1  raw PS/2 device clock, asynchronous to clk.
REQ-006 Port: PS2_DAT  input  1  raw PS/2 device data, asynchronous to clk.
REQ-007 Port: pressed  output  1  single-cycle pulse when a new letter key is pressed.
REQ-008 Port: inputLetter  output  5  letter index, 0 = A through 25 = Z; valid from the pressed pulse until the next pressed pulse.
REQ-009 Port: frame_err  output  1  single-cycle pulse when a frame is discarded.

Function
REQ-010 PS2_CLK and PS2_DAT SHALL pass through SYNC_STAGES flops; a bit edge is a 1->0 transition of synchronised PS2_CLK, detected in one clk cycle.
REQ-011 Receiver FSM: IDLE, DATA, PARITY, STOP; each transition occurs only on a bit edge.
REQ-012 IDLE: a sampled 0 (start bit) -> DATA with bit count 0; a sampled 1 -> remain in IDLE with no error.
REQ-013 DATA: shift 8 bits, LSB first; after bit 7 -> PARITY.
REQ-014 PARITY: store the sampled bit -> STOP.
REQ-015 STOP: sampled 1 -> byte accepted; sampled 0 -> frame_err pulse and byte discarded; either case -> IDLE.
REQ-016 Outside IDLE, TIMEOUT_CYCLES consecutive clk cycles without a bit edge -> IDLE, partial byte discarded, frame_err pulse.
REQ-017 Accepted byte is processed in cycle N+1, where N is the cycle of the stop-bit edge; a resulting pressed pulse is high in cycle N+2 exactly.
REQ-018 Byte 0xE0 sets ext; the next non-prefix byte is treated as non-letter and clears ext.
REQ-019 Byte 0xF0 sets brk; the next non-prefix byte is a release: clears brk; clears held if the code equals held_code; no pressed pulse.
REQ-020 Set-2 make-code map: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
REQ-021 Make code for a letter, with ext=0 and brk=0: if held=1 and code equals held_code, the byte is a typematic repeat and is suppressed; otherwise pressed pulses, inputLetter updates in the same cycle, held=1, held_code=code.
REQ-022 Non-letter make codes SHALL produce no pulse and leave held/held_code unchanged.
REQ-023 A new letter make while another letter is held SHALL pulse and replace held_code.
REQ-024 E0 followed by F0 (extended release) SHALL set both flags and be consumed by the next byte.
REQ-025 pressed and frame_err SHALL never be high for 2 consecutive cycles.

Reset
REQ-026 Reset SHALL asynchronously force: FSM IDLE, bit count 0, shift register 0, ext=brk=held=0, held_code=0, pressed=0, inputLetter=0, frame_err=0, timeout counter 0, sync flops 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; no pulse after release until a full new frame arrives.

Configuration
REQ-028 Macro PS2_PARITY_CHECK_EN defined: in STOP, a frame whose data+parity bits have even count of 1s SHALL be discarded with a frame_err pulse, exactly as a stop-bit error.
REQ-029 Macro PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored; frame_err arises only from REQ-015/REQ-016.

Verification
REQ-030 Frame 0x1C (parity 0, stop 1) -> pressed pulses once in cycle N+2 with inputLetter=0; then F0,1C -> no pulse and held cleared.
REQ-031 1C,1C,1C (typematic), then F0,1C, then 1C -> exactly two pressed pulses, both with inputLetter=0.
REQ-032 1A then 35 without a release -> two pulses, inputLetter=25 then 24; E0,1C -> no pulse, ext cleared.
REQ-033 Frame 0x24 with stop bit 0 -> frame_err pulse, no pressed; next valid 0x24 -> pressed with inputLetter=4.
REQ-034 PS2_CLK stalls after 4 data bits for 50000 cycles -> frame_err pulse and FSM IDLE; following frame 0x15 -> inputLetter=16.
REQ-035 With PS2_PARITY_CHECK_EN defined, 0x1C sent with parity 1 -> frame_err pulse, no pressed; without the macro -> pressed with inputLetter=0.
